// File: rtl/bitstream_pkg.sv
// Shared types for the bitstream decoder: controller state encoding.
package bitstream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/bitstream_counter.sv
// Per-lane ones counter: clear wins over enable, count lands one edge after its sample, saturates at WINDOW_LEN.
// No flow control of its own; the decoder gates enable.
module bitstream_counter #(
  parameter int WINDOW_LEN  = 256,
  parameter int COUNT_WIDTH = $clog2(WINDOW_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   clear,
  input  logic                   enable,
  input  logic                   bit_in,
  output logic [COUNT_WIDTH-1:0] count
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = COUNT_WIDTH'(WINDOW_LEN);

  logic [COUNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && bit_in && (count_q != COUNT_MAX)) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/bitstream_decoder.sv
// Converts NEURON_COUNT stochastic bitstreams into ones-counts and bipolar values over a WINDOW_LEN-sample window.
// Result valid WINDOW_LEN edges after start; held until out_ready, with start+out_ready chaining windows.
module bitstream_decoder #(
  parameter int NEURON_COUNT = 2,
  parameter int WINDOW_LEN   = 256,
  localparam int COUNT_WIDTH = $clog2(WINDOW_LEN + 1)
) (
  input  logic                                     clk,
  input  logic                                     n_rst,
  input  logic [NEURON_COUNT-1:0]                  stream_in,
  input  logic                                     start,
  input  logic                                     out_ready,
  output logic                                     busy,
  output logic                                     out_valid,
  output logic [NEURON_COUNT-1:0][COUNT_WIDTH-1:0] out_count,
  output logic [NEURON_COUNT-1:0][COUNT_WIDTH:0]   out_bipolar
);

  import bitstream_pkg::*;

  localparam logic [COUNT_WIDTH-1:0] LAST_SAMPLE  = COUNT_WIDTH'(WINDOW_LEN - 1);
  localparam logic [COUNT_WIDTH:0]   BIPOLAR_MAX  = (COUNT_WIDTH + 1)'(WINDOW_LEN);
  localparam logic [COUNT_WIDTH:0]   BIPOLAR_MIN  = (COUNT_WIDTH + 1)'(-WINDOW_LEN);
  localparam logic [COUNT_WIDTH:0]   BIPOLAR_STEP = (COUNT_WIDTH + 1)'(2);

  state_t                                   state_q, state_d;
  logic [COUNT_WIDTH-1:0]                   sample_q, sample_d;
  logic [NEURON_COUNT-1:0][COUNT_WIDTH:0]   bipolar_q, bipolar_d;
  logic                                     lane_clear;
  logic                                     lane_enable;

  always_comb begin
    state_d     = state_q;
    sample_d    = sample_q;
    lane_clear  = 1'b0;
    lane_enable = 1'b0;
    busy        = 1'b0;
    out_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          lane_clear = 1'b1;
          sample_d   = '0;
          state_d    = ACCUM;
        end
      end
      ACCUM: begin
        busy        = 1'b1;
        lane_enable = 1'b1;
        sample_d    = sample_q + COUNT_WIDTH'(1);
        if (sample_q == LAST_SAMPLE) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        // start only counts once the held result has been consumed
        if (out_ready) begin
          if (start) begin
            lane_clear = 1'b1;
            sample_d   = '0;
            state_d    = ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bipolar value kept as its own register: starts at -WINDOW_LEN and steps by 2 per one
  always_comb begin
    bipolar_d = bipolar_q;
    for (int i = 0; i < NEURON_COUNT; i++) begin
      if (lane_clear) begin
        bipolar_d[i] = BIPOLAR_MIN;
      end else if (lane_enable && stream_in[i] && (bipolar_q[i] != BIPOLAR_MAX)) begin
        bipolar_d[i] = bipolar_q[i] + BIPOLAR_STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      sample_q  <= '0;
      bipolar_q <= {NEURON_COUNT{BIPOLAR_MIN}};
    end else begin
      state_q   <= state_d;
      sample_q  <= sample_d;
      bipolar_q <= bipolar_d;
    end
  end

  for (genvar i = 0; i < NEURON_COUNT; i++) begin : g_lane
    bitstream_counter #(
      .WINDOW_LEN  (WINDOW_LEN),
      .COUNT_WIDTH (COUNT_WIDTH)
    ) u_counter (
      .clk    (clk),
      .n_rst  (n_rst),
      .clear  (lane_clear),
      .enable (lane_enable),
      .bit_in (stream_in[i]),
      .count  (out_count[i])
    );
  end

  assign out_bipolar = bipolar_q;

endmodule

// File: tb/tb_bitstream_decoder.sv
// Scoreboarded random bench for bitstream_decoder (WINDOW_LEN=16) plus a directed WINDOW_LEN=1 instance.
module tb_bitstream_decoder;

  localparam int WL  = 16;
  localparam int NC  = 2;
  localparam int CW  = $clog2(WL + 1);
  localparam int NWIN = 24;

  logic                    clk;
  logic                    n_rst;
  logic [NC-1:0]           stream_in;
  logic                    start;
  logic                    out_ready;
  logic                    busy;
  logic                    out_valid;
  logic [NC-1:0][CW-1:0]   out_count;
  logic [NC-1:0][CW:0]     out_bipolar;

  logic                    start1;
  logic [1:0]              stream1;
  logic                    ready1;
  logic                    busy1;
  logic                    valid1;
  logic [1:0][0:0]         count1;
  logic [1:0][1:0]         bip1;

  bitstream_decoder #(.NEURON_COUNT(NC), .WINDOW_LEN(WL)) u_dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .stream_in   (stream_in),
    .start       (start),
    .out_ready   (out_ready),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_count   (out_count),
    .out_bipolar (out_bipolar)
  );

  bitstream_decoder #(.NEURON_COUNT(2), .WINDOW_LEN(1)) u_dut1 (
    .clk         (clk),
    .n_rst       (n_rst),
    .stream_in   (stream1),
    .start       (start1),
    .out_ready   (ready1),
    .busy        (busy1),
    .out_valid   (valid1),
    .out_count   (count1),
    .out_bipolar (bip1)
  );

  typedef struct {
    int cnt0;
    int cnt1;
    int rise;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   mon_en = 0;
  bit   prev_valid = 0;
  bit   aborted = 0;
  int   busy_run = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares held results against the scoreboard head every cycle they are presented
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got out_valid=1 expected no pending window (cycle %0d)", cyc);
        end else begin
          mon_e = sb[0];
          if (!prev_valid) chk("valid_rise_cycle", cyc, mon_e.rise);
          chk("count_lane0", int'(out_count[0]), mon_e.cnt0);
          chk("count_lane1", int'(out_count[1]), mon_e.cnt1);
          chk("bipolar_lane0", int'($signed(out_bipolar[0])), 2 * mon_e.cnt0 - WL);
          chk("bipolar_lane1", int'($signed(out_bipolar[1])), 2 * mon_e.cnt1 - WL);
          if (out_ready) void'(sb.pop_front());
        end
      end
      if (busy) begin
        busy_run++;
      end else begin
        if (busy_run > 0 && !aborted) chk("busy_cycles", busy_run, WL);
        busy_run = 0;
      end
      aborted    = !n_rst ? 1'b1 : (busy ? aborted : 1'b0);
      prev_valid = out_valid;
    end
  end

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      total++;
      bad++;
      $display("FAIL wait_valid: got no out_valid within 40 cycles expected a result (cycle %0d)", cyc);
    end
  endtask

  // Hold the result with out_ready low while pulsing start, which must be ignored
  task automatic hold(input int n);
    for (int i = 0; i < n; i++) begin
      out_ready = 1'b0;
      start     = (i % 2 == 0);
      stream_in = NC'($urandom);
      tick();
    end
    start = 1'b0;
  endtask

  // Issues start (caller sets out_ready when releasing a held window) and feeds WL samples
  task automatic issue(input logic [WL-1:0] p0, input logic [WL-1:0] p1, input int poke);
    exp_t e;
    e.cnt0 = $countones(p0);
    e.cnt1 = $countones(p1);
    e.rise = cyc + 1 + WL;
    sb.push_back(e);
    start     = 1'b1;
    stream_in = NC'($urandom);
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < WL; k++) begin
      stream_in = {p1[k], p0[k]};
      start     = (k + 1 == poke);
      tick();
    end
    start     = 1'b0;
    stream_in = NC'($urandom);
  endtask

  task automatic release_idle();
    wait_valid();
    hold($urandom_range(0, 3));
    out_ready = 1'b1;
    start     = 1'b0;
    tick();
    out_ready = 1'b0;
    repeat ($urandom_range(0, 3)) begin
      stream_in = NC'($urandom);
      tick();
    end
  endtask

  initial begin
    logic [WL-1:0] p0, p1;
    int  poke;
    bit  pending;
    int  n;

    n_rst = 1'b0; start = 1'b0; stream_in = '0; out_ready = 1'b0;
    start1 = 1'b0; stream1 = '0; ready1 = 1'b0;
    repeat (3) tick();
    n_rst = 1'b1;
    tick();

    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_count0", int'(out_count[0]), 0);
    chk("rst_count1", int'(out_count[1]), 0);
    chk("rst_bipolar0", int'($signed(out_bipolar[0])), -WL);
    chk("rst_bipolar1", int'($signed(out_bipolar[1])), -WL);
    chk("rst1_bipolar0", int'($signed(bip1[0])), -1);
    mon_en = 1'b1;

    pending = 1'b0;
    for (int w = 0; w < NWIN; w++) begin
      poke = 0;
      case (w)
        0: begin p0 = '1; p1 = '0; end
        1: begin p0 = 16'h5555; p1 = 16'h5555; end
        2: begin p0 = '1; p1 = WL'($urandom); poke = 5; end
        default: begin p0 = WL'($urandom); p1 = WL'($urandom); end
      endcase
      if (pending) begin
        wait_valid();
        hold((w == 3) ? 5 : $urandom_range(0, 4));
        out_ready = 1'b1;
      end
      issue(p0, p1, poke);
      if (w == 2 || (w > 3 && $urandom_range(0, 1) == 1)) begin
        pending = 1'b1;
      end else begin
        release_idle();
        pending = 1'b0;
      end
    end
    if (pending) release_idle();

    // Reset after sample 7 discards the window
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) begin
      stream_in = NC'($urandom);
      tick();
    end
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_count0", int'(out_count[0]), 0);
    chk("midrst_count1", int'(out_count[1]), 0);
    chk("midrst_bipolar0", int'($signed(out_bipolar[0])), -WL);
    tick();
    p0 = WL'($urandom);
    p1 = '1;
    issue(p0, p1, 0);
    release_idle();

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("scoreboard_drained", sb.size(), 0);

    // WINDOW_LEN=1 instance
    stream1 = 2'b01;
    start1  = 1'b1;
    tick();
    start1 = 1'b0;
    chk("w1_busy_after_start", int'(busy1), 1);
    chk("w1_valid_after_start", int'(valid1), 0);
    tick();
    chk("w1_valid", int'(valid1), 1);
    chk("w1_busy_hold", int'(busy1), 0);
    chk("w1_count0", int'(count1[0]), 1);
    chk("w1_count1", int'(count1[1]), 0);
    chk("w1_bipolar0", int'($signed(bip1[0])), 1);
    chk("w1_bipolar1", int'($signed(bip1[1])), -1);
    start1 = 1'b1;
    tick();
    chk("w1_hold_valid", int'(valid1), 1);
    chk("w1_hold_count0", int'(count1[0]), 1);
    ready1  = 1'b1;
    start1  = 1'b1;
    stream1 = 2'b10;
    tick();
    ready1 = 1'b0;
    start1 = 1'b0;
    chk("w1_b2b_busy", int'(busy1), 1);
    tick();
    chk("w1_b2b_valid", int'(valid1), 1);
    chk("w1_b2b_count0", int'(count1[0]), 0);
    chk("w1_b2b_count1", int'(count1[1]), 1);
    chk("w1_b2b_bipolar0", int'($signed(bip1[0])), -1);
    chk("w1_b2b_bipolar1", int'($signed(bip1[1])), 1);
    ready1 = 1'b1;
    tick();
    ready1 = 1'b0;
    chk("w1_release_valid", int'(valid1), 0);
    chk("w1_release_busy", int'(busy1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
